maint_sched: RTL and testbench
==============================

# maint_sched

Maintenance scheduler for the DDR3 command path. It runs the refresh, ZQ-calibration and periodic-read interval timers and queues refreshes that have been postponed. It raises exactly one of `autoref_req`, `zq_req` or `pr_rd_req` at a time toward the maintenance handler, and holds that request until the handler acknowledges it. It also stalls the host instruction-sequence dispatcher when refresh postponement reaches its limit.

## Interface
Parameters:
- `CNT_WIDTH`, 28: width of the interval counters and interval inputs.
- `MAX_POSTPONE`, 8: maximum number of queued refreshes (1..15).

Ports:
- `clk`, in, 1: clock.
- `rst`, in, 1: reset, synchronous, active-high.
- `ref_en`, `zq_en`, `prd_en`, in, 1 each: per-type enables.
- `trefi`, `tzqi`, `tprd`, in, CNT_WIDTH each: intervals in clk cycles. A value of 0 disables that type.
- `dispatcher_idle`, in, 1: the host dispatcher is between instruction sequences.
- `host_rd`, in, 1: pulse when the host issues a DDR READ.
- `autoref_req`, out, 1; `autoref_ack`, in, 1: refresh handshake.
- `zq_req`, out, 1; `zq_ack`, in, 1: ZQ handshake.
- `pr_rd_req`, out, 1; `periodic_read_lock`, in, 1: periodic-read handshake.
- `host_stall`, out, 1: the dispatcher must not start a new sequence.
- `ref_pending`, out, 4: number of queued refreshes.
- `ref_overflow`, out, 1: sticky flag, set when a refresh is lost.

## Operation
- **Timers.** Each timer is a down-counter. It loads `interval-1` and decrements every cycle while its type is active (enable=1 and interval≠0).
  - At value 0 it emits a one-cycle expiry and reloads.
  - While inactive it is held at the reload value.
- **Refresh queue.**
  - A `trefi` expiry increments `ref_pending`. An `autoref_ack` decrements it.
  - If both happen in the same cycle, the count is unchanged.
  - An expiry while the count is already `MAX_POSTPONE` sets `ref_overflow` and leaves the count unchanged.
  - Dropping `ref_en` clears `ref_pending` but does not abort a request already in flight.
- **ZQ.** A `tzqi` expiry sets `zq_pend`. `zq_pend` clears when the ZQ request is granted (the FSM enters S_ZQ). Dropping `zq_en` clears it.
- **Periodic read.**
  - A `tprd` expiry sets `prd_pend`.
  - `host_rd` reloads the `tprd` timer and clears `prd_pend`, unless the FSM is already in S_PRD.
- **urgent** = (`ref_pending` == `MAX_POSTPONE`).
- **FSM states:** S_IDLE, S_REF, S_ZQ, S_PRD.
  - **S_IDLE** selects by priority, evaluated every cycle:
    1. urgent → S_REF, regardless of `dispatcher_idle`.
    2. `prd_pend` & `dispatcher_idle` → S_PRD.
    3. `zq_pend` & `dispatcher_idle` → S_ZQ.
    4. `ref_pending`>0 & `dispatcher_idle` → S_REF.
  - **S_REF:** `autoref_req`=1. On `autoref_ack` → S_IDLE.
  - **S_ZQ:** `zq_req`=1. On `zq_ack` → S_IDLE.
  - **S_PRD:** `pr_rd_req`=1. When `periodic_read_lock` is seen as 1 → clear `prd_pend`, reload the `tprd` timer, → S_IDLE.
- **`host_stall`** = urgent OR (state≠S_IDLE).
- **Mid-flight changes.** Enable or interval changes take effect at the next reload or in the idle hold. An FSM in S_REF/S_ZQ/S_PRD always waits for its ack.
- Handler acks that arrive in the wrong state are ignored, except that `autoref_ack` always decrements `ref_pending` (saturating at 0).

## Timing
- **Reset values:**
  - all outputs 0; `ref_pending`=0; `ref_overflow`=0;
  - FSM in S_IDLE; timers loaded with `interval-1`.
- The first refresh expiry occurs `trefi` cycles after reset release, with `ref_en`=1 held.
- **Expiry to request:** a pend/count update becomes visible the cycle after expiry. The request is asserted the cycle after that, from the registered FSM state. Total: 2 cycles.
- **Ack to deassert:**
  - The request deasserts in the cycle after the ack.
  - The next request can assert at the earliest 1 cycle later, since S_IDLE is occupied for at least one cycle.
- All request outputs are registered-state decodes and glitch-free. At most one request is high in any cycle.

## Test plan
- `trefi`=100, `ref_en`=1, `dispatcher_idle`=1, ack 5 cycles after each request → `autoref_req` rises at cycle 101 after reset release and every 100 cycles after that; `ref_pending` peaks at 1.
- `dispatcher_idle`=0, `trefi`=10, no acks → `ref_pending` counts 1..8. At 8, `host_stall`=1 and `autoref_req`=1 despite busy. The next expiry sets `ref_overflow`.
- `tprd`=50, `host_rd` pulsed every 30 cycles → `pr_rd_req` never asserts. Stop the pulses → `pr_rd_req` asserts 51 cycles after the last pulse and drops 1 cycle after `periodic_read_lock`=1.
- ZQ, periodic-read and non-urgent refresh pending together with `dispatcher_idle`=1 → service order is `pr_rd_req`, then `zq_req`, then `autoref_req`, one at a time.
- `autoref_ack` coincident with a `trefi` expiry at `ref_pending`=3 → stays 3. `rst` pulsed while in S_ZQ → `zq_req`=0 the next cycle and all counters are reset.

Source files
------------

// File: rtl/maint_sched.sv
// maint_sched: DDR3 refresh / ZQ / periodic-read interval timers and one-at-a-time maintenance request arbiter
module maint_sched #(
    parameter int CNT_WIDTH    = 28,
    parameter int MAX_POSTPONE = 8
) (
    input  logic                 clk,
    input  logic                 rst,
    input  logic                 ref_en,
    input  logic                 zq_en,
    input  logic                 prd_en,
    input  logic [CNT_WIDTH-1:0] trefi,
    input  logic [CNT_WIDTH-1:0] tzqi,
    input  logic [CNT_WIDTH-1:0] tprd,
    input  logic                 dispatcher_idle,
    input  logic                 host_rd,
    output logic                 autoref_req,
    input  logic                 autoref_ack,
    output logic                 zq_req,
    input  logic                 zq_ack,
    output logic                 pr_rd_req,
    input  logic                 periodic_read_lock,
    output logic                 host_stall,
    output logic [3:0]           ref_pending,
    output logic                 ref_overflow
);
    typedef enum logic [1:0] {S_IDLE, S_REF, S_ZQ, S_PRD} state_t;

    localparam logic [3:0] MAX_P = 4'(MAX_POSTPONE);

    state_t state, state_nx;
    logic [CNT_WIDTH-1:0] ref_cnt, zq_cnt, prd_cnt;
    logic ref_act, zq_act, prd_act;
    logic ref_exp, zq_exp, prd_exp;
    logic prd_rld, ref_dec, urgent, zq_pend, prd_pend;

    assign ref_act = ref_en && trefi != '0;
    assign zq_act  = zq_en && tzqi != '0;
    assign prd_act = prd_en && tprd != '0;
    assign ref_exp = ref_act && ref_cnt == '0;
    assign zq_exp  = zq_act && zq_cnt == '0;
    assign prd_exp = prd_act && prd_cnt == '0;
    // a host read already does the job of a periodic read, as does a completed one
    assign prd_rld = (host_rd && state != S_PRD) || (state == S_PRD && periodic_read_lock);
    assign ref_dec = autoref_ack && ref_pending != '0;
    assign urgent  = ref_pending == MAX_P;

    // interval down-counters: held at reload while inactive, reload on expiry
    always_ff @(posedge clk) begin
        if (rst) begin
            ref_cnt <= trefi - CNT_WIDTH'(1);
            zq_cnt  <= tzqi - CNT_WIDTH'(1);
            prd_cnt <= tprd - CNT_WIDTH'(1);
        end else begin
            ref_cnt <= (!ref_act || ref_exp) ? trefi - CNT_WIDTH'(1) : ref_cnt - CNT_WIDTH'(1);
            zq_cnt  <= (!zq_act || zq_exp) ? tzqi - CNT_WIDTH'(1) : zq_cnt - CNT_WIDTH'(1);
            prd_cnt <= (!prd_act || prd_exp || prd_rld) ? tprd - CNT_WIDTH'(1) : prd_cnt - CNT_WIDTH'(1);
        end
    end

    // postponed-refresh queue; an expiry with a full queue is lost and flagged
    always_ff @(posedge clk) begin
        if (rst) begin
            ref_pending  <= '0;
            ref_overflow <= 1'b0;
        end else if (!ref_en) begin
            ref_pending <= '0;
        end else if (ref_exp && !ref_dec) begin
            if (urgent)
                ref_overflow <= 1'b1;
            else
                ref_pending <= ref_pending + 4'd1;
        end else if (!ref_exp && ref_dec) begin
            ref_pending <= ref_pending - 4'd1;
        end
    end

    // ZQ and periodic-read pending flags
    always_ff @(posedge clk) begin
        if (rst) begin
            zq_pend  <= 1'b0;
            prd_pend <= 1'b0;
        end else begin
            zq_pend  <= zq_en && (zq_exp || (zq_pend && !(state == S_IDLE && state_nx == S_ZQ)));
            prd_pend <= prd_en && !prd_rld && (prd_exp || prd_pend);
        end
    end

    // FSM state register
    always_ff @(posedge clk) begin
        if (rst)
            state <= S_IDLE;
        else
            state <= state_nx;
    end

    // arbitration in idle; each service state waits for its own ack
    always_comb begin
        state_nx = state;
        unique case (state)
            S_IDLE: state_nx = urgent ? S_REF :
                               (prd_pend && dispatcher_idle) ? S_PRD :
                               (zq_pend && dispatcher_idle) ? S_ZQ :
                               (ref_pending != '0 && dispatcher_idle) ? S_REF : S_IDLE;
            S_REF:  state_nx = autoref_ack ? S_IDLE : S_REF;
            S_ZQ:   state_nx = zq_ack ? S_IDLE : S_ZQ;
            S_PRD:  state_nx = periodic_read_lock ? S_IDLE : S_PRD;
            default: state_nx = S_IDLE;
        endcase
    end

    assign autoref_req = state == S_REF;
    assign zq_req      = state == S_ZQ;
    assign pr_rd_req   = state == S_PRD;
    assign host_stall  = urgent || state != S_IDLE;
endmodule

// File: tb/tb_maint_sched.sv
// tb_maint_sched: directed scenarios plus randomized run against a time-arithmetic reference model
module tb_maint_sched;
    localparam int MAXP = 8;

    logic clk = 1'b0;
    logic rst = 1'b1;
    logic ref_en = 1'b0, zq_en = 1'b0, prd_en = 1'b0;
    logic [27:0] trefi = '0, tzqi = '0, tprd = '0;
    logic dispatcher_idle = 1'b0, host_rd = 1'b0;
    logic autoref_req, zq_req, pr_rd_req, host_stall, ref_overflow;
    logic autoref_ack = 1'b0, zq_ack = 1'b0, periodic_read_lock = 1'b0;
    logic [3:0] ref_pending;

    int n_checks = 0;
    int n_fail = 0;
    int cyc = 0;

    maint_sched dut (
        .clk(clk), .rst(rst),
        .ref_en(ref_en), .zq_en(zq_en), .prd_en(prd_en),
        .trefi(trefi), .tzqi(tzqi), .tprd(tprd),
        .dispatcher_idle(dispatcher_idle), .host_rd(host_rd),
        .autoref_req(autoref_req), .autoref_ack(autoref_ack),
        .zq_req(zq_req), .zq_ack(zq_ack),
        .pr_rd_req(pr_rd_req), .periodic_read_lock(periodic_read_lock),
        .host_stall(host_stall), .ref_pending(ref_pending), .ref_overflow(ref_overflow)
    );

    always #5 clk = ~clk;

    // cycle N = state after the Nth rising edge following the last edge that sampled rst=1
    task automatic tick();
        @(posedge clk);
        @(negedge clk);
        cyc++;
    endtask

    task automatic clear_cfg();
        ref_en = 0; zq_en = 0; prd_en = 0;
        trefi = '0; tzqi = '0; tprd = '0;
        dispatcher_idle = 0;
    endtask

    task automatic do_reset();
        rst = 1;
        host_rd = 0; autoref_ack = 0; zq_ack = 0; periodic_read_lock = 0;
        repeat (2) @(posedge clk);
        @(negedge clk);
        rst = 0;
        cyc = 0;
    endtask

    task automatic test_reset();
        clear_cfg();
        ref_en = 1; zq_en = 1; prd_en = 1;
        trefi = 28'd100; tzqi = 28'd200; tprd = 28'd300;
        do_reset();
        n_checks++;
        if ({autoref_req, zq_req, pr_rd_req, host_stall} !== 4'b0000) begin
            n_fail++;
            $display("FAIL reset_outputs: got %b expected 0000", {autoref_req, zq_req, pr_rd_req, host_stall});
        end
        n_checks++;
        if ({ref_pending, ref_overflow} !== 5'b0) begin
            n_fail++;
            $display("FAIL reset_queue: got pending=%0d ovf=%b expected 0/0", ref_pending, ref_overflow);
        end
    endtask

    task automatic test_refresh_period();
        int rises[$];
        int age = 0;
        int peak = 0;
        logic prev = 0;
        clear_cfg();
        ref_en = 1; trefi = 28'd100; dispatcher_idle = 1;
        do_reset();
        for (int n = 1; n <= 420; n++) begin
            tick();
            if (autoref_req && !prev) rises.push_back(cyc);
            prev = autoref_req;
            age = autoref_req ? age + 1 : 0;
            autoref_ack = (age == 5);
            if (int'(ref_pending) > peak) peak = int'(ref_pending);
        end
        autoref_ack = 0;
        n_checks++;
        if (rises.size() != 4) begin
            n_fail++;
            $display("FAIL refresh_count: got %0d rises expected 4", rises.size());
        end
        for (int k = 0; k < rises.size() && k < 4; k++) begin
            n_checks++;
            if (rises[k] != 101 + 100 * k) begin
                n_fail++;
                $display("FAIL refresh_rise%0d: got cycle %0d expected %0d", k, rises[k], 101 + 100 * k);
            end
        end
        n_checks++;
        if (peak != 1) begin
            n_fail++;
            $display("FAIL refresh_peak: got %0d expected 1", peak);
        end
    endtask

    task automatic test_postpone();
        clear_cfg();
        ref_en = 1; trefi = 28'd10; dispatcher_idle = 0;
        do_reset();
        for (int n = 1; n <= 90; n++) begin
            tick();
            if (cyc % 10 == 0 && cyc <= 80) begin
                n_checks++;
                if (int'(ref_pending) != cyc / 10) begin
                    n_fail++;
                    $display("FAIL postpone_count@%0d: got %0d expected %0d", cyc, ref_pending, cyc / 10);
                end
            end
            if (cyc == 79 || cyc == 80) begin
                n_checks++;
                if (host_stall !== (cyc == 80)) begin
                    n_fail++;
                    $display("FAIL postpone_stall@%0d: got %b expected %b", cyc, host_stall, cyc == 80);
                end
            end
            if (cyc == 81) begin
                n_checks++;
                if (autoref_req !== 1'b1) begin
                    n_fail++;
                    $display("FAIL postpone_urgent_req: got %b expected 1", autoref_req);
                end
            end
            if (cyc == 89 || cyc == 90) begin
                n_checks++;
                if (ref_overflow !== (cyc == 90)) begin
                    n_fail++;
                    $display("FAIL postpone_overflow@%0d: got %b expected %b", cyc, ref_overflow, cyc == 90);
                end
            end
            if (cyc == 90) begin
                n_checks++;
                if (ref_pending !== 4'd8) begin
                    n_fail++;
                    $display("FAIL postpone_saturate: got %0d expected 8", ref_pending);
                end
            end
        end
    endtask

    task automatic test_periodic_read();
        int early = 0;
        clear_cfg();
        prd_en = 1; tprd = 28'd50; dispatcher_idle = 1;
        do_reset();
        for (int n = 1; n <= 240; n++) begin
            tick();
            if (pr_rd_req && cyc < 231) early++;
            if (cyc == 230 || cyc == 231 || cyc == 234 || cyc == 235) begin
                n_checks++;
                if (pr_rd_req !== (cyc == 231 || cyc == 234)) begin
                    n_fail++;
                    $display("FAIL prd_req@%0d: got %b expected %b", cyc, pr_rd_req, cyc == 231 || cyc == 234);
                end
            end
            host_rd = (cyc % 30 == 29) && cyc <= 179;
            periodic_read_lock = (cyc == 234);
        end
        periodic_read_lock = 0;
        n_checks++;
        if (early != 0) begin
            n_fail++;
            $display("FAIL prd_suppressed: got %0d request cycles expected 0", early);
        end
    endtask

    task automatic test_priority();
        int order[$];
        int age = 0;
        int prev = 0;
        int code;
        int overlap = 0;
        clear_cfg();
        ref_en = 1; zq_en = 1; prd_en = 1;
        trefi = 28'd30; tzqi = 28'd40; tprd = 28'd45;
        do_reset();
        while (cyc < 60) tick();
        n_checks++;
        if (ref_pending !== 4'd2) begin
            n_fail++;
            $display("FAIL prio_setup: got pending %0d expected 2", ref_pending);
        end
        trefi = '0; tzqi = '0; tprd = '0;
        dispatcher_idle = 1;
        for (int n = 0; n < 60; n++) begin
            tick();
            code = autoref_req ? 1 : zq_req ? 2 : pr_rd_req ? 3 : 0;
            if ($countones({autoref_req, zq_req, pr_rd_req}) > 1) overlap++;
            if (code != 0 && prev != 0 && code != prev) overlap++;
            if (code != 0 && prev == 0) order.push_back(code);
            prev = code;
            age = code != 0 ? age + 1 : 0;
            autoref_ack = (age == 2) && code == 1;
            zq_ack = (age == 2) && code == 2;
            periodic_read_lock = (age == 2) && code == 3;
        end
        autoref_ack = 0; zq_ack = 0; periodic_read_lock = 0;
        n_checks++;
        if (order.size() < 3 || order[0] != 3 || order[1] != 2 || order[2] != 1) begin
            n_fail++;
            $display("FAIL prio_order: got %p expected 3,2,1 first", order);
        end
        n_checks++;
        if (overlap != 0) begin
            n_fail++;
            $display("FAIL prio_one_at_a_time: got %0d overlapping cycles expected 0", overlap);
        end
        n_checks++;
        if (ref_pending !== 4'd0) begin
            n_fail++;
            $display("FAIL prio_drain: got pending %0d expected 0", ref_pending);
        end
    endtask

    task automatic test_coincident();
        clear_cfg();
        ref_en = 1; trefi = 28'd10; dispatcher_idle = 0;
        do_reset();
        for (int n = 1; n <= 50; n++) begin
            tick();
            if (cyc == 30 || cyc == 40 || cyc == 46 || cyc == 50) begin
                n_checks++;
                if (int'(ref_pending) != (cyc == 46 ? 2 : 3)) begin
                    n_fail++;
                    $display("FAIL coincident@%0d: got %0d expected %0d", cyc, ref_pending, cyc == 46 ? 2 : 3);
                end
            end
            autoref_ack = (cyc == 39) || (cyc == 45);
        end
        autoref_ack = 0;
    endtask

    task automatic test_reset_in_zq();
        clear_cfg();
        zq_en = 1; tzqi = 28'd20; dispatcher_idle = 1;
        do_reset();
        while (cyc < 22) begin
            tick();
            if (cyc == 20 || cyc == 21) begin
                n_checks++;
                if (zq_req !== (cyc == 21)) begin
                    n_fail++;
                    $display("FAIL zq_req@%0d: got %b expected %b", cyc, zq_req, cyc == 21);
                end
            end
        end
        rst = 1;
        tick();
        rst = 0;
        cyc = 0;
        n_checks++;
        if ({zq_req, host_stall, ref_pending, ref_overflow} !== 7'b0) begin
            n_fail++;
            $display("FAIL zq_reset: got %b expected 0000000", {zq_req, host_stall, ref_pending, ref_overflow});
        end
        while (cyc < 21) begin
            tick();
            if (cyc == 20 || cyc == 21) begin
                n_checks++;
                if (zq_req !== (cyc == 21)) begin
                    n_fail++;
                    $display("FAIL zq_after_reset@%0d: got %b expected %b", cyc, zq_req, cyc == 21);
                end
            end
        end
    endtask

    // reference model: a timer of interval I reloaded at cycle R expires at cycle R+I-1
    task automatic test_random();
        int t, rl_r, rl_z, rl_p, m_pend, m_req, n_req;
        bit m_ovf, m_zq, m_prd, a_r, a_z, a_p, e_r, e_z, e_p, rld, dec;
        logic [8:0] exp_v, got_v;
        for (int r = 0; r < 6; r++) begin
            clear_cfg();
            trefi = 28'($urandom_range(4, 40));
            tzqi = 28'($urandom_range(0, 60));
            tprd = 28'($urandom_range(0, 50));
            ref_en = $urandom_range(0, 3) != 0;
            zq_en = $urandom_range(0, 3) != 0;
            prd_en = $urandom_range(0, 3) != 0;
            do_reset();
            t = 0; rl_r = 0; rl_z = 0; rl_p = 0; m_pend = 0; m_req = 0;
            m_ovf = 0; m_zq = 0; m_prd = 0;
            for (int n = 0; n < 1500; n++) begin
                exp_v = {m_req == 1, m_req == 2, m_req == 3, m_pend == MAXP || m_req != 0, 4'(m_pend), m_ovf};
                got_v = {autoref_req, zq_req, pr_rd_req, host_stall, ref_pending, ref_overflow};
                n_checks++;
                if (got_v !== exp_v) begin
                    n_fail++;
                    $display("FAIL random run%0d cycle%0d {ref,zq,prd,stall,pend,ovf}: got %b expected %b", r, t, got_v, exp_v);
                end
                dispatcher_idle = $urandom_range(0, 3) != 0;
                host_rd = $urandom_range(0, 15) == 0;
                autoref_ack = autoref_req ? $urandom_range(0, 3) == 0 : $urandom_range(0, 29) == 0;
                zq_ack = zq_req ? $urandom_range(0, 2) == 0 : $urandom_range(0, 29) == 0;
                periodic_read_lock = pr_rd_req ? $urandom_range(0, 2) == 0 : $urandom_range(0, 29) == 0;
                if (n % 300 == 299) begin
                    ref_en = $urandom_range(0, 3) != 0;
                    zq_en = $urandom_range(0, 3) != 0;
                    prd_en = $urandom_range(0, 3) != 0;
                end
                n_req = m_req;
                if (m_req == 0)
                    n_req = m_pend == MAXP ? 1 : (m_prd && dispatcher_idle) ? 3 :
                            (m_zq && dispatcher_idle) ? 2 : (m_pend > 0 && dispatcher_idle) ? 1 : 0;
                else if ((m_req == 1 && autoref_ack) || (m_req == 2 && zq_ack) || (m_req == 3 && periodic_read_lock))
                    n_req = 0;
                a_r = ref_en && trefi != 0;
                a_z = zq_en && tzqi != 0;
                a_p = prd_en && tprd != 0;
                e_r = a_r && (t - rl_r == int'(trefi) - 1);
                e_z = a_z && (t - rl_z == int'(tzqi) - 1);
                e_p = a_p && (t - rl_p == int'(tprd) - 1);
                rld = (host_rd && m_req != 3) || (m_req == 3 && periodic_read_lock);
                if (!a_r || e_r) rl_r = t + 1;
                if (!a_z || e_z) rl_z = t + 1;
                if (!a_p || e_p || rld) rl_p = t + 1;
                dec = autoref_ack && m_pend > 0;
                if (!ref_en) m_pend = 0;
                else if (e_r && !dec) begin
                    if (m_pend == MAXP) m_ovf = 1;
                    else m_pend++;
                end else if (!e_r && dec) m_pend--;
                m_zq = zq_en && (e_z || (m_zq && !(m_req == 0 && n_req == 2)));
                m_prd = prd_en && !rld && (e_p || m_prd);
                m_req = n_req;
                t++;
                tick();
            end
        end
        host_rd = 0; autoref_ack = 0; zq_ack = 0; periodic_read_lock = 0;
    endtask

    initial begin
        test_reset();
        test_refresh_period();
        test_postpone();
        test_periodic_read();
        test_priority();
        test_coincident();
        test_reset_in_zq();
        test_random();
        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end
endmodule
